// File: rtl/mem_stall_if.sv
// Pipeline <-> stall controller bundle: memory handshake, hazard inputs,
// stall/flush outputs and status. master = pipeline/memory side, slave = controller.
interface mem_stall_if #(
  parameter int CNT_W = 32
);
  logic             MemAccessM;
  logic             mem_ready;
  logic [3:0]       A1_addrD;
  logic [3:0]       A2_addrD;
  logic [3:0]       A3_addrE;
  logic             MemtoRegE;
  logic             RegWriteE;
  logic             mem_req;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             StallW;
  logic             FlushE;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output MemAccessM, mem_ready, A1_addrD, A2_addrD, A3_addrE, MemtoRegE, RegWriteE,
    input  mem_req, StallF, StallD, StallE, StallM, StallW, FlushE, mem_err, stall_cnt
  );

  modport slave (
    input  MemAccessM, mem_ready, A1_addrD, A2_addrD, A3_addrE, MemtoRegE, RegWriteE,
    output mem_req, StallF, StallD, StallE, StallM, StallW, FlushE, mem_err, stall_cnt
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Pipeline stall/flush controller: freezes all stages during variable-latency
// M-stage memory accesses and inserts a bubble on load-use hazards.
module mem_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst_p,
  mem_stall_if.slave  bus
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_cnt_next;
  logic             r_mem_err;
  logic             w_mem_err_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_memstall;
  logic             w_mem_req;
  logic             w_lu;

  assign w_lu = bus.MemtoRegE & bus.RegWriteE &
                ((bus.A3_addrE == bus.A1_addrD) | (bus.A3_addrE == bus.A2_addrD));

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_mem_err  <= w_mem_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_err_next  = r_mem_err;
    w_memstall      = 1'b0;
    w_mem_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mem_req = bus.MemAccessM;
        if (bus.MemAccessM && !bus.mem_ready) begin
          w_memstall      = 1'b1;
          w_state_next    = S_WAIT;
          w_wait_cnt_next = WC_W'(1);
        end
      end
      S_WAIT: begin
        // MemAccessM is frozen by the stall, so only the memory response matters here.
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_state_next    = S_IDLE;
          w_wait_cnt_next = '0;
        end else if (r_wait_cnt == WC_W'(TIMEOUT)) begin
          w_memstall     = 1'b1;
          w_state_next   = S_ERR;
          w_mem_err_next = 1'b1;
        end else begin
          w_memstall      = 1'b1;
          w_wait_cnt_next = r_wait_cnt + WC_W'(1);
        end
      end
      S_ERR: begin
        w_memstall = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_stall_cnt <= '0;
    end else if (w_memstall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Memory stall wins over the load-use bubble; the hazard is seen again after release.
  assign bus.mem_req   = w_mem_req;
  assign bus.StallF    = w_memstall | w_lu;
  assign bus.StallD    = w_memstall | w_lu;
  assign bus.StallE    = w_memstall;
  assign bus.StallM    = w_memstall;
  assign bus.StallW    = w_memstall;
  assign bus.FlushE    = ~w_memstall & w_lu;
  assign bus.mem_err   = r_mem_err;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_mem_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_p;
  always #5 clk = ~clk;

  mem_stall_if #(.CNT_W(CNT_W)) bus ();

  mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // {mem_req, StallF, StallD, StallE, StallM, StallW, FlushE}
  function automatic logic [6:0] ctrl_now();
    return {bus.mem_req, bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW, bus.FlushE};
  endfunction

  task automatic chk_ctrl(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = ctrl_now();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: ctrl got %b need %b", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp);
    total++;
    if (bus.stall_cnt !== CNT_W'(exp)) begin
      bad++;
      $display("FAIL %s: stall_cnt got %0d need %0d", name, bus.stall_cnt, exp);
    end
  endtask

  task automatic chk_err(input string name, input logic exp);
    total++;
    if (bus.mem_err !== exp) begin
      bad++;
      $display("FAIL %s: mem_err got %b need %b", name, bus.mem_err, exp);
    end
  endtask

  task automatic set_in(input logic acc, input logic rdy, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3,
                        input logic mtr, input logic rw);
    bus.MemAccessM = acc;
    bus.mem_ready  = rdy;
    bus.A1_addrD   = a1;
    bus.A2_addrD   = a2;
    bus.A3_addrE   = a3;
    bus.MemtoRegE  = mtr;
    bus.RegWriteE  = rw;
  endtask

  // One cycle: inputs change 1 after the edge, outputs are sampled 4 after it.
  task automatic apply(input logic acc, input logic rdy, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] a3,
                       input logic mtr, input logic rw);
    @(posedge clk);
    #1;
    set_in(acc, rdy, a1, a2, a3, mtr, rw);
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_p = 1'b1;
    set_in(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    #4;
    rst_p = 1'b0;
  endtask

  // Behavioural model: an outstanding request, how long it has waited, a sticky
  // error, and a saturating count of frozen cycles.
  bit m_pending;
  int m_waited;
  bit m_err;
  int m_cnt;

  function automatic logic [6:0] model_ctrl(input logic acc, input logic rdy, input bit lu);
    bit frozen;
    bit req;
    frozen = m_err || (m_pending ? !rdy : (acc && !rdy));
    req    = !m_err && (m_pending || acc);
    return {req, frozen || lu, frozen || lu, frozen, frozen, frozen, !frozen && lu};
  endfunction

  task automatic model_reset();
    m_pending = 0;
    m_waited  = 0;
    m_err     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_clock(input logic acc, input logic rdy);
    bit frozen;
    frozen = m_err || (m_pending ? !rdy : (acc && !rdy));
    if (frozen && m_cnt < CNT_MAX) m_cnt++;
    if (m_err) begin
      // stays frozen until reset
    end else if (m_pending) begin
      if (rdy) begin
        m_pending = 0;
        m_waited  = 0;
      end else if (m_waited >= TIMEOUT) begin
        m_err = 1;
      end else begin
        m_waited++;
      end
    end else if (acc && !rdy) begin
      m_pending = 1;
      m_waited  = 1;
    end
  endtask

  typedef struct {
    string      name;
    logic       acc;
    logic       rdy;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [3:0] a3;
    logic       mtr;
    logic       rw;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{"idle",        0, 0, 4'd1, 4'd2, 4'd3, 0, 0, 7'b0000000};
    tbl[1] = '{"zero_wait",   1, 1, 4'd1, 4'd2, 4'd3, 0, 0, 7'b1000000};
    tbl[2] = '{"lu_a1",       0, 0, 4'd5, 4'd1, 4'd5, 1, 1, 7'b0110001};
    tbl[3] = '{"lu_a2",       0, 0, 4'd2, 4'd9, 4'd9, 1, 1, 7'b0110001};
    tbl[4] = '{"lu_no_wr",    0, 0, 4'd5, 4'd1, 4'd5, 1, 0, 7'b0000000};
    tbl[5] = '{"lu_no_load",  0, 0, 4'd5, 4'd1, 4'd5, 0, 1, 7'b0000000};
    tbl[6] = '{"lu_no_match", 0, 0, 4'd1, 4'd2, 4'd3, 1, 1, 7'b0000000};
    tbl[7] = '{"zw_plus_lu",  1, 1, 4'd7, 4'd0, 4'd7, 1, 1, 7'b1110001};
    tbl[8] = '{"lu_reg0",     0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 7'b0110001};

    rst_p = 1'b1;
    set_in(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    #12;
    rst_p = 1'b0;
    #2;
    chk_ctrl("reset_ctrl", 7'b0000000);
    chk_cnt("reset_cnt", 0);
    chk_err("reset_err", 1'b0);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].acc, tbl[i].rdy, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].mtr, tbl[i].rw);
      chk_ctrl(tbl[i].name, tbl[i].exp);
    end
    apply(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    chk_cnt("table_cnt", 0);
    chk_err("table_err", 1'b0);

    // 3-cycle memory: three frozen cycles, released on the ready cycle.
    do_reset();
    apply(1, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("k3_c0", 7'b1111110); chk_cnt("k3_c0", 0);
    apply(1, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("k3_c1", 7'b1111110); chk_cnt("k3_c1", 1);
    apply(0, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("k3_c2", 7'b1111110); chk_cnt("k3_c2", 2);
    apply(1, 1, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("k3_rdy", 7'b1000000); chk_cnt("k3_rdy", 3);
    apply(0, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("k3_idle", 7'b0000000); chk_cnt("k3_end", 3);

    // Load-use during a memory wait: stall wins, bubble appears after release.
    do_reset();
    apply(1, 0, 4'd5, 4'd1, 4'd5, 1, 1); chk_ctrl("lum_c0", 7'b1111110);
    apply(0, 0, 4'd5, 4'd1, 4'd5, 1, 1); chk_ctrl("lum_c1", 7'b1111110);
    apply(0, 1, 4'd5, 4'd1, 4'd5, 1, 1); chk_ctrl("lum_rdy", 7'b1110001); chk_cnt("lum_rdy", 2);
    apply(0, 0, 4'd5, 4'd1, 4'd5, 1, 1); chk_ctrl("lum_after", 7'b0110001);

    // Timeout: four WAIT cycles, then sticky ERR; saturation of the 4-bit counter.
    do_reset();
    apply(1, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("to_idle", 7'b1111110);
    for (int w = 1; w <= TIMEOUT; w++) begin
      apply(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
      chk_ctrl($sformatf("to_wait%0d", w), 7'b1111110);
      chk_cnt($sformatf("to_wait%0d", w), w);
      chk_err($sformatf("to_wait%0d", w), 1'b0);
    end
    apply(0, 1, 4'd1, 4'd2, 4'd3, 0, 0);
    chk_ctrl("to_err", 7'b0111110); chk_err("to_err", 1'b1); chk_cnt("to_err", TIMEOUT + 1);
    for (int c = 0; c < 14; c++) apply(c[0], 1, 4'd1, 4'd2, 4'd3, 0, 0);
    chk_ctrl("err_hold", 7'b0111110); chk_err("err_sticky", 1'b1); chk_cnt("sat", CNT_MAX);

    // Asynchronous reset in the middle of a WAIT cycle.
    do_reset();
    apply(1, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    apply(0, 0, 4'd1, 4'd2, 4'd3, 0, 0); chk_ctrl("arst_pre", 7'b1111110); chk_cnt("arst_pre", 1);
    rst_p = 1'b1;
    #1;
    chk_ctrl("arst_ctrl", 7'b0000000); chk_cnt("arst_cnt", 0); chk_err("arst_err", 1'b0);
    rst_p = 1'b0;

    // Randomized traffic against the model, with a reset at the start of each burst.
    for (int chunk = 0; chunk < 8; chunk++) begin
      do_reset();
      model_reset();
      for (int i = 0; i < 50; i++) begin
        logic       acc, rdy, mtr, rw;
        logic [3:0] a1, a2, a3;
        logic [6:0] exp;
        bit         lu;
        acc = 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 9) < ((chunk % 2 == 1) ? 3 : 7));
        a1  = 4'($urandom_range(0, 3));
        a2  = 4'($urandom_range(0, 3));
        a3  = 4'($urandom_range(0, 3));
        mtr = 1'($urandom_range(0, 1));
        rw  = 1'($urandom_range(0, 1));
        lu  = mtr && rw && (a3 == a1 || a3 == a2);
        apply(acc, rdy, a1, a2, a3, mtr, rw);
        exp = model_ctrl(acc, rdy, lu);
        chk_ctrl($sformatf("rnd%0d_%0d", chunk, i), exp);
        chk_cnt($sformatf("rnd%0d_%0d", chunk, i), m_cnt);
        chk_err($sformatf("rnd%0d_%0d", chunk, i), logic'(m_err));
        model_clock(acc, rdy);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
